// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - double-buffered parallel-to-serial front end (optional parity: SER_PARITY_EN)
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);
  localparam int OUT_BIT = MSB_FIRST ? WIDTH - 1 : 0;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_full, hold_full_n;
  logic [CW-1:0]    bitcnt, bitcnt_n;
  logic             active, last, load, accept;
`ifdef SER_PARITY_EN
  logic             par, par_n;
`endif

  // Move the next bit toward the output end of the shift register.
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
    else           return {1'b0, v[WIDTH-1:1]};
  endfunction

  assign active    = (state == SHIFT);
  assign last      = active && (bitcnt == LAST_CNT);
  assign load      = !active || last;
  assign din_ready = !hold_full && !rst;
  assign accept    = din_valid && din_ready;

  // Next-state: reload from hold first, else bypass din, else go idle or keep shifting.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    hold_n      = hold;
    hold_full_n = hold_full;
    bitcnt_n    = bitcnt;
`ifdef SER_PARITY_EN
    par_n       = par;
`endif
    if (load && hold_full) begin
      shreg_n     = hold;
      hold_full_n = 1'b0;
      state_n     = SHIFT;
      bitcnt_n    = '0;
`ifdef SER_PARITY_EN
      par_n       = ^hold;
`endif
    end else if (load && accept) begin
      shreg_n  = din;
      state_n  = SHIFT;
      bitcnt_n = '0;
`ifdef SER_PARITY_EN
      par_n    = ^din;
`endif
    end else if (load) begin
      state_n  = IDLE;
      bitcnt_n = '0;
    end else begin
      shreg_n  = shift_out(shreg);
      bitcnt_n = bitcnt + CW'(1);
      if (accept) begin
        hold_n      = din;
        hold_full_n = 1'b1;
      end
    end
  end

  // State register; reset drops any frame in flight and any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bitcnt    <= '0;
`ifdef SER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      bitcnt    <= bitcnt_n;
`ifdef SER_PARITY_EN
      par       <= par_n;
`endif
    end
  end

`ifdef SER_PARITY_EN
  assign sout = active && ((bitcnt == CW'(WIDTH)) ? par : shreg[OUT_BIT]);
`else
  assign sout = active && shreg[OUT_BIT];
`endif
  assign sout_valid  = active;
  assign frame_start = active && (bitcnt == '0);
  assign busy        = active || hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - self-checking bench for bit_serializer (both bit orders)
module tb_bit_serializer;
  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int FL  = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int FL  = W;
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic rdy_m, sout_m, sv_m, fs_m, busy_m;
  logic rdy_l, sout_l, sv_l, fs_l, busy_l;

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level model: position in the current frame, plus one pending word.
  int           pos = -1;
  bit           held = 1'b0;
  logic [W-1:0] hw = '0;
  logic [32:0]  fr_m = '0, fr_l = '0;
  bit           macc;

  bit log_m[$];
  bit log_l[$];
  int fs_cnt = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
    .sout(sout_m), .sout_valid(sv_m), .frame_start(fs_m), .busy(busy_m));

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
    .sout(sout_l), .sout_valid(sv_l), .frame_start(fs_l), .busy(busy_l));

  // Transmit order of a word as a bit list, index 0 first on the wire.
  function automatic logic [32:0] mkframe(input logic [W-1:0] w, input bit msb);
    logic [32:0] f;
    f = '0;
    for (int i = 0; i < W; i++) f[i] = msb ? w[W-1-i] : w[i];
    if (PAR) f[W] = ^w;
    return f;
  endfunction

  function automatic logic [31:0] pack(input bit q[$], input int first, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = first; i < first + n; i++) v = {v[30:0], q[i]};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Model advance: finish/continue the frame, then start the next from hold or din.
  always @(posedge clk) begin
    if (rst) begin
      pos  = -1;
      held = 1'b0;
    end else begin
      macc = din_valid && !held;
      if (pos >= 0) pos++;
      if (pos == FL) pos = -1;
      if (pos < 0) begin
        if (held) begin
          fr_m = mkframe(hw, 1'b1);
          fr_l = mkframe(hw, 1'b0);
          pos  = 0;
          held = 1'b0;
        end else if (macc) begin
          fr_m = mkframe(din, 1'b1);
          fr_l = mkframe(din, 1'b0);
          pos  = 0;
        end
      end else if (macc) begin
        hw   = din;
        held = 1'b1;
      end
    end
  end

  // Every-cycle comparison of both instances against the model, away from the edge.
  always @(negedge clk) begin
    logic ev, esm, esl;
    ev  = (pos >= 0);
    esm = 1'b0;
    esl = 1'b0;
    if (ev) begin
      esm = fr_m[pos];
      esl = fr_l[pos];
    end
    chk("m_sout_valid", sv_m, ev);
    chk("m_sout", sout_m, esm);
    chk("m_frame_start", fs_m, pos == 0);
    chk("m_busy", busy_m, ev || held);
    chk("m_din_ready", rdy_m, !held && !rst);
    chk("l_sout_valid", sv_l, ev);
    chk("l_sout", sout_l, esl);
    chk("l_frame_start", fs_l, pos == 0);
    chk("l_busy", busy_l, ev || held);
    chk("l_din_ready", rdy_l, !held && !rst);
    if (sv_m) log_m.push_back(sout_m);
    if (sv_l) log_l.push_back(sout_l);
    if (fs_m) fs_cnt++;
  end

  task automatic clear_logs();
    log_m.delete();
    log_l.delete();
    fs_cnt = 0;
  endtask

  // Present a word and hold it until accepted; leaves din_valid high.
  task automatic put(input logic [W-1:0] w);
    bit done, r;
    done = 1'b0;
    din = w;
    din_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      r = rdy_m;
      @(posedge clk);
      #2;
      if (r) done = 1'b1;
    end
    if (!done) chk("put_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    @(negedge clk);
    chk("rst_din_ready", rdy_m, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_sout_valid", sv_m, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", rdy_m, 1);
    @(posedge clk);
    #2;

    // Single word 0xB0.
    clear_logs();
    put(8'hB0);
    idle(14);
    chk("b0_len", log_m.size(), W + (PAR ? 1 : 0));
    chk("b0_bits", pack(log_m, 0, 8), 32'hB0);
    chk("b0_detector_1011", pack(log_m, 0, 4), 32'hB);
    chk("b0_frame_starts", fs_cnt, 1);
    chk("b0_lsb_order", pack(log_l, 0, 8), 32'h0D);

    // Back-to-back 0xB5, 0x0F with din_valid held.
    clear_logs();
    put(8'hB5);
    put(8'h0F);
    idle(24);
    chk("b2b_first", pack(log_m, 0, 8), 32'hB5);
    chk("b2b_second", pack(log_m, FL, 8), 32'h0F);
    chk("b2b_frame_starts", fs_cnt, 2);

    // Bypass: second word offered exactly on the last-bit cycle.
    clear_logs();
    put(8'h3C);
    din_valid = 1'b0;
    repeat (FL - 1) @(posedge clk);
    #2;
    put(8'hC3);
    idle(24);
    chk("bypass_first", pack(log_m, 0, 8), 32'h3C);
    chk("bypass_second", pack(log_m, FL, 8), 32'hC3);
    chk("bypass_frame_starts", fs_cnt, 2);

    // Reset at bit 3 of 0xFF with 0xAA held.
    clear_logs();
    put(8'hFF);
    put(8'hAA);
    din_valid = 1'b0;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", rdy_m, 0);
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("rst_mid_sout_valid", sv_m, 0);
    chk("rst_mid_busy", busy_m, 0);
    chk("rst_mid_ready_held", rdy_m, 0);
    chk("pre_reset_bits", log_m.size(), 4);
    chk("pre_reset_value", pack(log_m, 0, 4), 32'hF);
    @(posedge clk);
    #2;
    rst = 1'b0;
    clear_logs();
    idle(15);
    chk("no_remnant_bits", log_m.size(), 0);

    // 0x0D on the LSB-first instance.
    clear_logs();
    put(8'h0D);
    idle(14);
    chk("lsb_0d", pack(log_l, 0, 8), 32'hB0);

`ifdef SER_PARITY_EN
    // Parity frames back to back: 0x07 (parity 1) then 0x81 (parity 0).
    clear_logs();
    put(8'h07);
    put(8'h81);
    idle(26);
    chk("par_len", log_m.size(), 18);
    chk("par_frame1", pack(log_m, 0, 9), 32'h00F);
    chk("par_frame2", pack(log_m, 9, 9), 32'h102);
    chk("par_frame_starts", fs_cnt, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
